// File: rtl/mem_rd_align_merge_pkg.sv
// Shared types and width helpers for the load align/merge datapath.
// Optional feature macro used across the slice: SIGN_EXT_EN.
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC1    = 2'd1,
        ACC2    = 2'd2,
        IO_WAIT = 2'd3
    } state_t;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int sz_width(input int out_bytes);
        return $clog2(out_bytes);
    endfunction

endpackage

// File: rtl/mem_rd_align_merge_if.sv
// Request, dcache/IO read and result bundle for mem_rd_align_merge.
// req_signed exists only when SIGN_EXT_EN is defined.
interface mem_rd_align_merge_if #(
    parameter int LINE_BYTES = 16,
    parameter int OUT_BYTES  = 8,
    parameter int IO_W       = 32
);
    import mem_rd_pkg::*;

    localparam int OFF_W = off_width(LINE_BYTES);
    localparam int SZ_W  = sz_width(OUT_BYTES);

    logic                    req_valid;
    logic                    req_ready;
    logic [OFF_W-1:0]        req_offset;
    logic [SZ_W-1:0]         req_size_m1;
    logic                    req_io;
`ifdef SIGN_EXT_EN
    logic                    req_signed;
`endif
    logic [LINE_BYTES*8-1:0] dc_rd_data;
    logic                    dc_hit;
    logic                    dc_miss_ack;
    logic [IO_W-1:0]         io_rd_data;
    logic                    io_ack;
    logic                    flush;
    logic                    access2;
    logic                    busy;
    logic                    rd_valid;
    logic [OUT_BYTES*8-1:0]  rd_data;

    modport master (
`ifdef SIGN_EXT_EN
        output req_signed,
`endif
        output req_valid, req_offset, req_size_m1, req_io,
        output dc_rd_data, dc_hit, dc_miss_ack, io_rd_data, io_ack, flush,
        input  req_ready, access2, busy, rd_valid, rd_data
    );

    modport slave (
`ifdef SIGN_EXT_EN
        input  req_signed,
`endif
        input  req_valid, req_offset, req_size_m1, req_io,
        input  dc_rd_data, dc_hit, dc_miss_ack, io_rd_data, io_ack, flush,
        output req_ready, access2, busy, rd_valid, rd_data
    );

endinterface

// File: rtl/byte_rotate_right.sv
// Byte-granular right rotation of an N-byte word; returns the low OUT_N bytes.
// Out byte i = in byte (i + shift) mod N_BYTES (N_BYTES is a power of two).
module byte_rotate_right #(
    parameter int N_BYTES = 16,
    parameter int OUT_N   = N_BYTES,
    parameter int SH_W    = $clog2(N_BYTES)
) (
    input  logic [N_BYTES*8-1:0] i_data,
    input  logic [SH_W-1:0]      i_shift,
    output logic [OUT_N*8-1:0]   o_data
);

    logic [SH_W-1:0] w_idx;

    // Modulo wrap comes for free from the SH_W-bit index add
    always_comb begin
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < OUT_N; i++) begin
            w_idx = SH_W'(i) + i_shift;
            o_data[i*8 +: 8] = i_data[{w_idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/mem_rd_merge_mask.sv
// Per-byte hold-vs-new-line select, size keep mask and line-split flag
// derived from the request byte offset and size.
module mem_rd_merge_mask
    import mem_rd_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int OUT_BYTES  = 8,
    parameter int OFF_W      = off_width(LINE_BYTES),
    parameter int SZ_W       = sz_width(OUT_BYTES)
) (
    input  logic [OFF_W-1:0]     i_offset,
    input  logic [SZ_W-1:0]      i_size_m1,
    output logic [OUT_BYTES-1:0] o_hold_sel,
    output logic [OUT_BYTES-1:0] o_keep,
    output logic                 o_split
);

    logic [OFF_W:0]   w_first_cnt;
    logic [OFF_W+1:0] w_end;

    // Bytes below first_cnt come from the first line, the rest from the second
    always_comb begin
        w_first_cnt = (OFF_W+1)'(LINE_BYTES) - {1'b0, i_offset};
        w_end       = {2'b00, i_offset} + (OFF_W+2)'(i_size_m1) + (OFF_W+2)'(1);
        o_split     = (w_end > (OFF_W+2)'(LINE_BYTES));
        o_hold_sel  = '0;
        o_keep      = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            o_hold_sel[i] = ((OFF_W+1)'(i) < w_first_cnt);
            o_keep[i]     = (SZ_W'(i) <= i_size_m1);
        end
    end

endmodule

// File: rtl/mem_rd_align_merge.sv
// Load data aligner: rotates dcache line data to the request offset, merges
// line-crossing loads from two hits, returns IO reads; optional SIGN_EXT_EN.
module mem_rd_align_merge
    import mem_rd_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int OUT_BYTES  = 8,
    parameter int IO_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_rd_align_merge_if.slave   rd_if
);

    localparam int OFF_W = off_width(LINE_BYTES);
    localparam int SZ_W  = sz_width(OUT_BYTES);
    localparam int OW    = OUT_BYTES * 8;

    state_t              r_state;
    logic [OFF_W-1:0]    r_offset;
    logic [SZ_W-1:0]     r_size_m1;
    logic                r_io;
    logic [OW-1:0]       r_hold;
    logic [OW-1:0]       r_rd_data;
    logic                r_rd_valid;
    logic                r_access2;
    logic                r_busy;
    logic                r_req_ready;

    logic [OW-1:0]        w_rot;
    logic [OW-1:0]        w_merged;
    logic [OW-1:0]        w_io_ext;
    logic [OW-1:0]        w_raw;
    logic [OW-1:0]        w_result;
    logic [OUT_BYTES-1:0] w_hold_sel;
    logic [OUT_BYTES-1:0] w_keep;
    logic                 w_split;
    logic                 w_hit;
    logic                 w_done;
    logic                 w_signed;
    logic [7:0]           w_fill;
    logic [SZ_W+2:0]      w_msb_bit;

`ifdef SIGN_EXT_EN
    logic r_signed;
    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    byte_rotate_right #(
        .N_BYTES (LINE_BYTES),
        .OUT_N   (OUT_BYTES),
        .SH_W    (OFF_W)
    ) u_rot (
        .i_data  (rd_if.dc_rd_data),
        .i_shift (r_offset),
        .o_data  (w_rot)
    );

    mem_rd_merge_mask #(
        .LINE_BYTES (LINE_BYTES),
        .OUT_BYTES  (OUT_BYTES),
        .OFF_W      (OFF_W),
        .SZ_W       (SZ_W)
    ) u_mask (
        .i_offset   (r_offset),
        .i_size_m1  (r_size_m1),
        .o_hold_sel (w_hold_sel),
        .o_keep     (w_keep),
        .o_split    (w_split)
    );

    assign w_hit = rd_if.dc_hit & ~rd_if.dc_miss_ack;

    // Completion condition for the current state
    always_comb begin
        case (r_state)
            ACC1:    w_done = w_hit & ~w_split;
            ACC2:    w_done = w_hit;
            IO_WAIT: w_done = rd_if.io_ack;
            default: w_done = 1'b0;
        endcase
    end

    // Build raw result, then replace bytes above the access size with fill
    always_comb begin
        w_io_ext                = {OW{w_signed & rd_if.io_rd_data[IO_W-1]}};
        w_io_ext[IO_W-1:0]      = rd_if.io_rd_data;
        w_merged                = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            w_merged[i*8 +: 8] = w_hold_sel[i] ? r_hold[i*8 +: 8] : w_rot[i*8 +: 8];
        end
        if (r_io) begin
            w_raw = w_io_ext;
        end else if (r_state == ACC2) begin
            w_raw = w_merged;
        end else begin
            w_raw = w_rot;
        end
        w_msb_bit = {r_size_m1, 3'b111};
        w_fill    = {8{w_signed & w_raw[w_msb_bit]}};
        w_result  = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            w_result[i*8 +: 8] = w_keep[i] ? w_raw[i*8 +: 8] : w_fill;
        end
    end

    // Request FSM with registered outputs; flush overrides any completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_offset    <= '0;
            r_size_m1   <= '0;
            r_io        <= 1'b0;
`ifdef SIGN_EXT_EN
            r_signed    <= 1'b0;
`endif
            r_hold      <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_access2   <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else if (rd_if.flush) begin
            r_state     <= IDLE;
            r_rd_valid  <= 1'b0;
            r_access2   <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rd_if.req_valid) begin
                        r_offset    <= rd_if.req_offset;
                        r_size_m1   <= rd_if.req_size_m1;
                        r_io        <= rd_if.req_io;
`ifdef SIGN_EXT_EN
                        r_signed    <= rd_if.req_signed;
`endif
                        r_state     <= rd_if.req_io ? IO_WAIT : ACC1;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                    end
                end
                ACC1: begin
                    if (w_hit && w_split) begin
                        r_hold    <= w_rot;
                        r_state   <= ACC2;
                        r_access2 <= 1'b1;
                    end
                end
                ACC2:    ;
                IO_WAIT: ;
                default: begin
                    r_state     <= IDLE;
                    r_access2   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
            if (w_done) begin
                r_rd_data   <= w_result;
                r_rd_valid  <= 1'b1;
                r_state     <= IDLE;
                r_access2   <= 1'b0;
                r_busy      <= 1'b0;
                r_req_ready <= 1'b1;
            end
        end
    end

    assign rd_if.req_ready = r_req_ready;
    assign rd_if.access2   = r_access2;
    assign rd_if.busy      = r_busy;
    assign rd_if.rd_valid  = r_rd_valid;
    assign rd_if.rd_data   = r_rd_data;

endmodule

// File: tb/tb_mem_rd_align_merge.sv
// Directed self-checking bench for mem_rd_align_merge (default 16/8/32 config).
module tb_mem_rd_align_merge;

    localparam logic [127:0] LINE1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] LINE2 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_rd_align_merge_if #(.LINE_BYTES(16), .OUT_BYTES(8), .IO_W(32)) bus_if ();

    mem_rd_align_merge #(
        .LINE_BYTES (16),
        .OUT_BYTES  (8),
        .IO_W       (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rd_if (bus_if.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] off, input logic [2:0] sz, input logic io);
        bus_if.req_offset  = off;
        bus_if.req_size_m1 = sz;
        bus_if.req_io      = io;
        bus_if.req_valid   = 1'b1;
        step();
        bus_if.req_valid   = 1'b0;
    endtask

    initial begin
        bus_if.req_valid   = 1'b0;
        bus_if.req_offset  = '0;
        bus_if.req_size_m1 = '0;
        bus_if.req_io      = 1'b0;
`ifdef SIGN_EXT_EN
        bus_if.req_signed  = 1'b0;
`endif
        bus_if.dc_rd_data  = '0;
        bus_if.dc_hit      = 1'b0;
        bus_if.dc_miss_ack = 1'b0;
        bus_if.io_rd_data  = '0;
        bus_if.io_ack      = 1'b0;
        bus_if.flush       = 1'b0;

        step();
        step();
        chk("rst_rd_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("rst_rd_data", bus_if.rd_data, 64'd0);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'd1);
        chk("rst_access2", 64'(bus_if.access2), 64'd0);
        rst = 1'b0;
        step();

        // Hit and IO ack while idle are ignored
        bus_if.dc_hit = 1'b1;
        bus_if.io_ack = 1'b1;
        bus_if.dc_rd_data = LINE1;
        step();
        bus_if.dc_hit = 1'b0;
        bus_if.io_ack = 1'b0;
        chk("idle_stray_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("idle_stray_busy", 64'(bus_if.busy), 64'd0);

        // Non-split load, offset 4, 4 bytes
        issue(4'd4, 3'd3, 1'b0);
        chk("t1_busy", 64'(bus_if.busy), 64'd1);
        chk("t1_ready_low", 64'(bus_if.req_ready), 64'd0);
        bus_if.dc_hit = 1'b1;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t1_valid", 64'(bus_if.rd_valid), 64'd1);
        chk("t1_data", bus_if.rd_data, 64'h0000_0000_0706_0504);
        chk("t1_ready", 64'(bus_if.req_ready), 64'd1);
        step();
        chk("t1_pulse", 64'(bus_if.rd_valid), 64'd0);
        chk("t1_hold", bus_if.rd_data, 64'h0000_0000_0706_0504);

        // Split load, offset 12, 8 bytes
        issue(4'd12, 3'd7, 1'b0);
        bus_if.dc_rd_data = LINE1;
        bus_if.dc_hit = 1'b1;
        step();
        chk("t2_access2", 64'(bus_if.access2), 64'd1);
        chk("t2_no_valid", 64'(bus_if.rd_valid), 64'd0);
        bus_if.dc_rd_data = LINE2;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t2_valid", 64'(bus_if.rd_valid), 64'd1);
        chk("t2_data", bus_if.rd_data, 64'h1312_1110_0F0E_0D0C);
        chk("t2_access2_off", 64'(bus_if.access2), 64'd0);

        // Hits masked by miss ack for 3 cycles; new request while busy ignored
        issue(4'd0, 3'd7, 1'b0);
        bus_if.dc_rd_data  = LINE1;
        bus_if.dc_hit      = 1'b1;
        bus_if.dc_miss_ack = 1'b1;
        bus_if.req_valid   = 1'b1;
        bus_if.req_offset  = 4'd5;
        repeat (3) step();
        chk("t3_no_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("t3_busy", 64'(bus_if.busy), 64'd1);
        chk("t3_no_access2", 64'(bus_if.access2), 64'd0);
        bus_if.req_valid   = 1'b0;
        bus_if.dc_miss_ack = 1'b0;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t3_valid", 64'(bus_if.rd_valid), 64'd1);
        chk("t3_data", bus_if.rd_data, 64'h0706_0504_0302_0100);

        // IO read with stray dcache hits
        issue(4'd0, 3'd7, 1'b1);
        bus_if.io_rd_data = 32'hDEAD_BEEF;
        bus_if.dc_rd_data = LINE2;
        bus_if.dc_hit = 1'b1;
        repeat (5) step();
        chk("t4_no_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("t4_busy", 64'(bus_if.busy), 64'd1);
        bus_if.io_ack = 1'b1;
        step();
        bus_if.io_ack = 1'b0;
        bus_if.dc_hit = 1'b0;
        chk("t4_valid", 64'(bus_if.rd_valid), 64'd1);
        chk("t4_data", bus_if.rd_data, 64'h0000_0000_DEAD_BEEF);

        // Last-byte offset with 2 bytes must split; io_ack in ACC1 ignored
        issue(4'd15, 3'd1, 1'b0);
        bus_if.io_ack = 1'b1;
        step();
        bus_if.io_ack = 1'b0;
        chk("t5_ioack_ignored", 64'(bus_if.rd_valid), 64'd0);
        chk("t5_busy", 64'(bus_if.busy), 64'd1);
        bus_if.dc_rd_data = LINE1;
        bus_if.dc_hit = 1'b1;
        step();
        chk("t5_access2", 64'(bus_if.access2), 64'd1);
        bus_if.dc_rd_data = LINE2;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t5_data", bus_if.rd_data, 64'h0000_0000_0000_100F);

        // first_cnt equal to OUT_BYTES: no split
        issue(4'd8, 3'd7, 1'b0);
        bus_if.dc_rd_data = LINE1;
        bus_if.dc_hit = 1'b1;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t6_access2", 64'(bus_if.access2), 64'd0);
        chk("t6_valid", 64'(bus_if.rd_valid), 64'd1);
        chk("t6_data", bus_if.rd_data, 64'h0F0E_0D0C_0B0A_0908);

        // 3-byte access masks upper bytes
        issue(4'd2, 3'd2, 1'b0);
        bus_if.dc_hit = 1'b1;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t6_mask", bus_if.rd_data, 64'h0000_0000_0004_0302);

        // Flush coincident with completing ACC2 hit
        issue(4'd12, 3'd7, 1'b0);
        bus_if.dc_rd_data = LINE1;
        bus_if.dc_hit = 1'b1;
        step();
        chk("t7_access2", 64'(bus_if.access2), 64'd1);
        bus_if.dc_rd_data = LINE2;
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        bus_if.dc_hit = 1'b0;
        chk("t7_no_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("t7_data_kept", bus_if.rd_data, 64'h0000_0000_0004_0302);
        chk("t7_idle_ready", 64'(bus_if.req_ready), 64'd1);
        chk("t7_busy", 64'(bus_if.busy), 64'd0);
        chk("t7_access2_off", 64'(bus_if.access2), 64'd0);
        step();
        chk("t7_still_none", 64'(bus_if.rd_valid), 64'd0);

        // Asynchronous reset during ACC1
        issue(4'd0, 3'd7, 1'b0);
        chk("t8_busy_before", 64'(bus_if.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t8_rst_data", bus_if.rd_data, 64'd0);
        chk("t8_rst_busy", 64'(bus_if.busy), 64'd0);
        chk("t8_rst_ready", 64'(bus_if.req_ready), 64'd1);
        bus_if.dc_rd_data = LINE1;
        bus_if.dc_hit = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus_if.dc_hit = 1'b0;
        chk("t8_discarded", 64'(bus_if.rd_valid), 64'd0);
        chk("t8_idle", 64'(bus_if.busy), 64'd0);

`ifdef SIGN_EXT_EN
        // Signed 2-byte load and signed IO read
        bus_if.req_signed = 1'b1;
        issue(4'd0, 3'd1, 1'b0);
        bus_if.dc_rd_data = 128'h8001;
        bus_if.dc_hit = 1'b1;
        step();
        bus_if.dc_hit = 1'b0;
        chk("sx_load", bus_if.rd_data, 64'hFFFF_FFFF_FFFF_8001);
        issue(4'd0, 3'd7, 1'b1);
        bus_if.io_rd_data = 32'hDEAD_BEEF;
        bus_if.io_ack = 1'b1;
        step();
        bus_if.io_ack = 1'b0;
        chk("sx_io", bus_if.rd_data, 64'hFFFF_FFFF_DEAD_BEEF);
        bus_if.req_signed = 1'b0;
        issue(4'd0, 3'd1, 1'b0);
        bus_if.dc_hit = 1'b1;
        step();
        bus_if.dc_hit = 1'b0;
        chk("sx_unsigned", bus_if.rd_data, 64'h0000_0000_0000_8001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
